// File: rtl/instr_mem_pkg.sv
// Shared types for the instruction memory pipe.
//   ERR_* : rsp_err encoding returned with every response
//   rsp_t : one buffered response {data, err}
package instr_mem_pkg;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_PARITY   = 2'b11;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  err;
  } rsp_t;

endpackage

// File: rtl/instr_mem_rsp_fifo.sv
// 2-entry first-word-fall-through response buffer.
//   clka/rsta : clock, synchronous active-high reset
//   push/din  : word arriving from the read stage
//   pop       : consumer takes the head this cycle
//   vld/dout  : head present / head word (zero when nothing is present)
//   count     : number of stored entries (0..2)
// A word pushed while the buffer is empty is visible on dout in the same
// cycle; if it is also popped that cycle it is never stored.
module instr_mem_rsp_fifo #(
  parameter int W = 34
) (
  input  logic         clka,
  input  logic         rsta,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         vld,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] e0, e1;
  logic         empty;
  logic         push_st;
  logic         pop_st;

  assign empty   = (count == 2'd0);
  assign vld     = !empty || push;
  assign dout    = !empty ? e0 : (push ? din : '0);
  // Pass-through word consumed immediately is not stored.
  assign push_st = push && !(empty && pop);
  assign pop_st  = pop && !empty;

  always_ff @(posedge clka) begin
    if (rsta) begin
      count <= 2'd0;
      e0    <= '0;
      e1    <= '0;
    end else begin
      case ({push_st, pop_st})
        2'b10: begin
          if (count != 2'd2) begin
            if (empty) e0 <= din;
            else       e1 <= din;
            count <= count + 2'd1;
          end
        end
        2'b01: begin
          e0    <= e1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            e0 <= din;
          end else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_mem_pipe.sv
// Instruction memory for the fetch stage: synchronous-read word array with
// valid/ready request and response handshakes, address checking and a
// program-load write port.
//   clka, rsta          : clock, synchronous active-high reset
//   ena                 : global enable, gates request acceptance
//   req_valid/req_ready : fetch request handshake, req_addr = byte address
//   rsp_valid/rsp_ready : response handshake, rsp_data/rsp_err = head word
//   ld_en/ld_addr/ld_data : program-load write port
// Optional feature: define INSTR_MEM_PARITY_EN to store a parity bit per
// word and report ERR_PARITY on a mismatch.
module instr_mem_pipe
  import instr_mem_pkg::*;
#(
  parameter  int DEPTH  = 1024,
  parameter  int ADDR_W = 32,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              ena,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [1:0]        rsp_err,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data
);

`ifdef INSTR_MEM_PARITY_EN
  localparam int MW = 33;
`else
  localparam int MW = 32;
`endif

  logic [MW-1:0]    mem [DEPTH];
  logic [MW-1:0]    rd_q;
  logic [MW-1:0]    wword;
  logic [1:0]       err_q;
  logic             inflight;
  logic [1:0]       count;
  logic [1:0]       occ;
  logic             accept;
  logic [IDX_W-1:0] idx, ld_idx;
  logic [1:0]       req_err;
  logic             ld_ok;
  rsp_t             st, head;
  logic             fifo_vld;
  logic             unused_ld_lsb;

  assign unused_ld_lsb = ^ld_addr[1:0];

  // Occupancy counts the read in flight so the buffer never overflows.
  assign occ       = count + {1'b0, inflight};
  assign req_ready = ena && !ld_en && !rsta && (occ < 2'd2);
  assign accept    = req_valid && req_ready;

  assign idx    = req_addr[IDX_W+1:2];
  assign ld_idx = ld_addr[IDX_W+1:2];
  assign ld_ok  = ~|(ld_addr >> (IDX_W + 2));

  // Misalignment wins over range.
  always_comb begin
    req_err = ERR_OK;
    if (|req_addr[1:0])                 req_err = ERR_MISALIGN;
    else if (|(req_addr >> (IDX_W + 2))) req_err = ERR_RANGE;
  end

`ifdef INSTR_MEM_PARITY_EN
  assign wword = {^ld_data, ld_data};
`else
  assign wword = ld_data;
`endif

  // Array: no reset, so it maps onto block RAM.
  always_ff @(posedge clka) begin
    if (ld_en && ld_ok) mem[ld_idx] <= wword;
    if (accept)         rd_q <= mem[idx];
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      inflight <= 1'b0;
      err_q    <= ERR_OK;
    end else begin
      inflight <= accept;
      if (accept) err_q <= req_err;
    end
  end

  // Read-stage result; any error zeroes the word.
  always_comb begin
    st.data = rd_q[31:0];
    st.err  = err_q;
`ifdef INSTR_MEM_PARITY_EN
    if (err_q == ERR_OK && (^rd_q)) st.err = ERR_PARITY;
`endif
    if (st.err != ERR_OK) st.data = '0;
  end

  instr_mem_rsp_fifo #(.W($bits(rsp_t))) u_fifo (
    .clka  (clka),
    .rsta  (rsta),
    .push  (inflight),
    .din   (st),
    .pop   (rsp_valid && rsp_ready),
    .vld   (fifo_vld),
    .dout  (head),
    .count (count)
  );

  // Outputs held quiet while reset is asserted.
  assign rsp_valid = fifo_vld && !rsta;
  assign rsp_data  = rsta ? 32'h0 : head.data;
  assign rsp_err   = rsta ? ERR_OK : head.err;

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Self-checking bench for instr_mem_pipe (DEPTH=1024, ADDR_W=32).
module tb_instr_mem_pipe;

`ifdef INSTR_MEM_PARITY_EN
  localparam bit PAR = 1'b1;
  logic [32:0] dep;
`else
  localparam bit PAR = 1'b0;
  logic [31:0] dep;
`endif

  logic        clka = 1'b0;
  logic        rsta, ena, req_valid, req_ready, rsp_valid, rsp_ready, ld_en;
  logic [31:0] req_addr, ld_addr, ld_data, rsp_data;
  logic [1:0]  rsp_err;

  instr_mem_pipe dut (
    .clka(clka), .rsta(rsta), .ena(ena),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  always #5 clka = ~clka;

  typedef struct { logic [31:0] data; logic [1:0] err; } mrsp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic [1:0] err; } vec_t;

  // Reference model: word array, corruption flags, queue of owed responses.
  logic [31:0] mem_m [1024];
  bit          bad   [1024];
  mrsp_t       q[$];
  int          nvec = 0, nbad = 0, n_acc = 0;
  vec_t        tbl[8];

  function automatic mrsp_t exp_rsp(logic [31:0] a);
    mrsp_t r;
    logic [9:0] i;
    i = a[11:2];
    if (a[1:0] != 2'b00)     r = '{32'h0, 2'b01};
    else if ((a >> 12) != 0) r = '{32'h0, 2'b10};
    else if (bad[i] && PAR)  r = '{32'h0, 2'b11};
    else                     r = '{mem_m[i], 2'b00};
    return r;
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // One cycle: inputs already driven after a falling edge.
  task automatic tick();
    bit exp_ready, exp_valid, acc, pop;
    logic [31:0] a, la, ldd;
    bit lde;
    mrsp_t t;
    #1;
    exp_ready = ena && !ld_en && !rsta && (q.size() < 2);
    exp_valid = !rsta && (q.size() > 0);
    chk("req_ready", req_ready, exp_ready);
    chk("rsp_valid", rsp_valid, exp_valid);
    if (rsp_valid && exp_valid) begin
      chk("rsp_data", rsp_data, q[0].data);
      chk("rsp_err", rsp_err, q[0].err);
    end
    acc = req_valid && exp_ready;
    pop = exp_valid && rsp_ready;
    a = req_addr; lde = ld_en; la = ld_addr; ldd = ld_data;
    @(posedge clka);
    if (rsta) q.delete();
    else begin
      if (pop) t = q.pop_front();
      if (acc) begin q.push_back(exp_rsp(a)); n_acc++; end
    end
    if (lde && (la >> 12) == 0) begin
      mem_m[la[11:2]] = ldd;
      bad[la[11:2]] = 1'b0;
    end
    @(negedge clka);
  endtask

  task automatic ld(input logic [31:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, cyc;
    rsta = 1'b1; ena = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; ld_en = 1'b0;
    req_addr = '0; ld_addr = '0; ld_data = '0;
    @(negedge clka);
    tick(); tick();
    rsta = 1'b0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_err", rsp_err, 2'b00);
    chk("rst_req_ready", req_ready, 1'b1);

    // Program load, including a dropped out-of-range load that aliases word 0.
    ld(32'h0, 32'h00404713);
    ld(32'h4, 32'h00404693);
    for (int i = 2; i < 16; i++) ld(i * 4, $urandom);
    ld(32'h0FFC, 32'hDEADBEEF);
    ld(32'h2000, 32'h11111111);

    // Back-to-back stream.
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0;
    tick();
    req_addr = 32'h4;
    #1;
    chk("b2b_first_valid", rsp_valid, 1'b1);
    chk("b2b_first_data", rsp_data, 32'h00404713);
    tick();
    req_valid = 1'b0;
    #1;
    chk("b2b_second_data", rsp_data, 32'h00404693);
    chk("b2b_second_err", rsp_err, 2'b00);
    tick();

    tbl[0] = '{32'h0000_0000, 32'h00404713, 2'b00};
    tbl[1] = '{32'h0000_0004, 32'h00404693, 2'b00};
    tbl[2] = '{32'h0000_0006, 32'h0,        2'b01};
    tbl[3] = '{32'h0000_1000, 32'h0,        2'b10};
    tbl[4] = '{32'h0000_1002, 32'h0,        2'b01};
    tbl[5] = '{32'h0000_0FFC, 32'hDEADBEEF, 2'b00};
    tbl[6] = '{32'h8000_0000, 32'h0,        2'b10};
    tbl[7] = '{32'h0000_0FFF, 32'h0,        2'b01};
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_addr = tbl[i].addr;
      tick();
      req_valid = 1'b0;
      #1;
      chk("tbl_valid", rsp_valid, 1'b1);
      chk("tbl_data", rsp_data, tbl[i].data);
      chk("tbl_err", rsp_err, tbl[i].err);
      tick();
    end

    // Backpressure: only two of four requests fit while the consumer stalls.
    rsp_ready = 1'b0; base = n_acc;
    for (int c = 0; c < 4; c++) begin
      req_valid = 1'b1; req_addr = (n_acc - base) * 4;
      tick();
    end
    chk("bp_accepted", n_acc - base, 2);
    #1;
    chk("bp_ready_low", req_ready, 1'b0);
    rsp_ready = 1'b1; cyc = 0;
    while ((n_acc - base) < 4 && cyc < 20) begin
      req_addr = (n_acc - base) * 4;
      tick(); cyc++;
    end
    req_valid = 1'b0; cyc = 0;
    while (q.size() > 0 && cyc < 10) begin tick(); cyc++; end
    chk("bp_all_accepted", n_acc - base, 4);
    chk("bp_drained", q.size(), 0);
    tick();

    // Load blocks a concurrent request; next-cycle read sees new data.
    ld_en = 1'b1; ld_addr = 32'h8; ld_data = 32'hCAFEF00D;
    req_valid = 1'b1; req_addr = 32'h8;
    #1;
    chk("ld_blocks_req", req_ready, 1'b0);
    tick();
    ld_en = 1'b0;
    tick();
    req_valid = 1'b0;
    #1;
    chk("ld_then_read", rsp_data, 32'hCAFEF00D);
    tick();

    // Reset with two buffered responses.
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h4; cyc = 0;
    while (q.size() < 2 && cyc < 6) begin tick(); cyc++; end
    req_valid = 1'b0;
    tick();
    chk("pre_rst_buffered", q.size(), 2);
    rsta = 1'b1; req_valid = 1'b1;
    #1;
    chk("in_rst_ready", req_ready, 1'b0);
    tick();
    rsta = 1'b0; req_valid = 1'b0;
    #1;
    chk("post_rst_valid", rsp_valid, 1'b0);
    chk("post_rst_err", rsp_err, 2'b00);
    chk("post_rst_data", rsp_data, 32'h0);
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'hC;
    tick();
    req_valid = 1'b0;
    #1;
    chk("post_rst_read", rsp_data, mem_m[3]);
    tick();

    // Corrupt a stored bit behind the array's back.
    dep = dut.mem[5];
    dep[0] = ~dep[0];
    dut.mem[5] = dep;
    mem_m[5] = mem_m[5] ^ 32'h1;
    bad[5] = 1'b1;
    req_valid = 1'b1; req_addr = 32'h14;
    tick();
    req_valid = 1'b0;
    #1;
    chk("par_err", rsp_err, PAR ? 2'b11 : 2'b00);
    chk("par_data", rsp_data, PAR ? 32'h0 : mem_m[5]);
    tick();
    ld(32'h14, $urandom);

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      int r;
      rsta      = ($urandom_range(0, 99) == 0);
      ena       = ($urandom_range(0, 7) != 0);
      rsp_ready = ($urandom_range(0, 1) != 0);
      req_valid = ($urandom_range(0, 3) != 0);
      ld_en     = !rsta && ($urandom_range(0, 7) == 0);
      r = $urandom_range(0, 15);
      if (r < 12)       req_addr = $urandom_range(0, 15) * 4;
      else if (r < 14)  req_addr = $urandom_range(0, 63) | 32'h1;
      else if (r == 14) req_addr = 32'h1000 + $urandom_range(0, 255) * 4;
      else              req_addr = $urandom | 32'h8000_0000;
      ld_addr = ($urandom_range(0, 7) == 0) ? (32'h4000 | ($urandom_range(0, 15) * 4))
                                            : ($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      ld_data = $urandom;
      tick();
    end
    rsta = 1'b0; ena = 1'b1; req_valid = 1'b0; ld_en = 1'b0; rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    chk("final_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
